control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter MEM_TIMEOUT, default 16, max cycles spent waiting on mem_busy before error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 instr_ready  input  1  instruction memory has valid instr_data this cycle.
REQ-006 instr_data  input  32  fetched instruction word.
REQ-007 mem_busy  input  1  data memory still servicing current load/store.
REQ-008 alu_branch  input  1  ALU branch-condition result.
REQ-009 alu_result  input  32  ALU result, used as JALR target.
REQ-010 pc  output  32  current program counter.
REQ-011 instr_req  output  1  request fetch at address pc.
REQ-012 instr  output  32  latched instruction; feeds ALU opcode/funct3/funct7 fields.
REQ-013 immediate  output  32  sign-extended immediate decoded from instr.
REQ-014 alu_source  output  1  1 = ALU uses immediate, 0 = reg2.
REQ-015 mem_read, mem_write  output  1 each  data-memory strobes.
REQ-016 reg_write  output  1  register-file write enable, one cycle.
REQ-017 error  output  1  sticky fault flag.
REQ-018 state  output  3  encoded FSM state for debug.

Function
REQ-019 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5; codes 6-7 go to ERROR next cycle.
REQ-020 FETCH: instr_req=1 held until instr_ready=1; on that edge instr<=instr_data, go DECODE.
REQ-021 DECODE: legal opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111, 1100111; any other opcode -> ERROR, else EXEC.
REQ-022 immediate SHALL be combinational from instr per RV32I I/S/B/U/J formats, sign-extended to 32 bits; U-type passes instr[31:12] in bits [19:0] (ALU shifts); R-type yields 0.
REQ-023 alu_source=1 for opcodes 0010011, 0000011, 0100011, 0110111, 1100111; else 0.
REQ-024 EXEC lasts one cycle; load/store -> MEM, all others -> WB.
REQ-025 MEM: mem_read (load) or mem_write (store) asserted every MEM cycle; exit to WB on first cycle mem_busy=0.
REQ-026 MEM wait counter SHALL reach MEM_TIMEOUT cycles with mem_busy=1 -> ERROR, strobes drop.
REQ-027 WB lasts one cycle, reg_write=1 for all opcodes except 0100011 and 1100011, then FETCH.
REQ-028 PC update on WB exit: branch with alu_branch=1 -> pc+imm_B; JAL -> pc+imm_J; JALR -> {alu_result[31:1],1'b0}; else pc+4; 32-bit arithmetic wraps modulo 2^32.
REQ-029 alu_branch SHALL be sampled only in WB; ignored in all other states.
REQ-030 ERROR: error=1, all strobes 0, pc frozen; exits only via reset.
REQ-031 instr_ready outside FETCH and mem_busy outside MEM SHALL be ignored.
REQ-032 Minimum instruction latency: 4 cycles non-memory, 5 cycles memory (zero-wait fetch and memory).

Reset
REQ-033 nrst=0 SHALL immediately force state=FETCH, pc=RESET_PC, instr=0, error=0, wait counter=0; all strobes 0 while nrst=0.
REQ-034 Reset asserted mid-MEM or mid-fetch SHALL abort the access with no reg_write and no pc change beyond RESET_PC.
REQ-035 First instr_req SHALL assert in the first cycle after nrst deasserts.

Verification
REQ-036 ADDI 0x00500093, instr_ready immediate -> states 0,1,2,4,0; reg_write pulse in WB; immediate=5; pc 0->4.
REQ-037 BEQ offset +8 (0x00000463) with alu_branch=1 at pc=0x10 -> pc=0x18; alu_branch=0 -> pc=0x14; reg_write never asserted.
REQ-038 SW with mem_busy high 3 cycles -> mem_write high 4 MEM cycles, WB, reg_write=0, pc+4.
REQ-039 LW with mem_busy stuck high, MEM_TIMEOUT=16 -> ERROR after 16 MEM cycles, error=1, pc frozen until nrst.
REQ-040 Opcode 7'b1111111 -> ERROR after DECODE; nrst pulse mid-ERROR -> pc=RESET_PC, error=0, instr_req=1 next cycle.
REQ-041 JALR with alu_result=0x0000_0103 -> pc=0x0000_0102, reg_write=1.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and its instruction memory, data memory and ALU.
interface control_sequencer_if;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic        mem_busy;
  logic        alu_branch;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        instr_req;
  logic [31:0] instr;
  logic [31:0] immediate;
  logic        alu_source;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        error;
  logic [2:0]  state;

  // Sequencer side
  modport master (
    input  instr_ready, instr_data, mem_busy, alu_branch, alu_result,
    output pc, instr_req, instr, immediate, alu_source,
           mem_read, mem_write, reg_write, error, state
  );

  // Memory / ALU side
  modport slave (
    output instr_ready, instr_data, mem_busy, alu_branch, alu_result,
    input  pc, instr_req, instr, immediate, alu_source,
           mem_read, mem_write, reg_write, error, state
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory, writeback.
module control_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                nrst,
  control_sequencer_if.master bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  state_e            r_state;
  state_e            w_next_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_instr;
  logic [XLEN-1:0]   w_next_pc;
  logic [XLEN-1:0]   w_imm;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic              r_instr_req;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_reg_write;
  logic              r_error;
  logic              w_instr_req;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_reg_write;
  logic              w_error;

  logic [OPC_W-1:0]  w_opcode;
  logic              w_legal;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_branch;
  logic              w_is_jal;
  logic              w_is_jalr;
  logic              w_writes_rd;
  logic              w_alu_src;
  logic              w_fetch_accept;

  assign w_opcode       = r_instr[OPC_W-1:0];
  // Fetch completes only while the request is actually visible to memory
  assign w_fetch_accept = r_instr_req && bus.instr_ready;

  // Opcode classification of the latched instruction
  always_comb begin
    w_legal     = 1'b1;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    w_writes_rd = 1'b1;
    w_alu_src   = 1'b0;
    case (w_opcode)
      OP_R:      ;
      OP_I:      w_alu_src = 1'b1;
      OP_LOAD:   begin w_is_load = 1'b1; w_alu_src = 1'b1; end
      OP_STORE:  begin w_is_store = 1'b1; w_alu_src = 1'b1; w_writes_rd = 1'b0; end
      OP_BRANCH: begin w_is_branch = 1'b1; w_writes_rd = 1'b0; end
      OP_LUI:    w_alu_src = 1'b1;
      OP_JAL:    w_is_jal = 1'b1;
      OP_JALR:   begin w_is_jalr = 1'b1; w_alu_src = 1'b1; end
      default:   begin w_legal = 1'b0; w_writes_rd = 1'b0; end
    endcase
  end

  // Sign-extended immediate by instruction format; U-type left unshifted for the ALU
  always_comb begin
    w_imm = '0;
    case (w_opcode)
      OP_I, OP_LOAD, OP_JALR:
        w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
      OP_STORE:
        w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      OP_BRANCH:
        w_imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                 r_instr[11:8], 1'b0};
      OP_LUI:
        w_imm = {{12{r_instr[31]}}, r_instr[31:12]};
      OP_JAL:
        w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                 r_instr[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  // Program counter taken on WB exit; alu_branch only matters here
  always_comb begin
    w_next_pc = r_pc + XLEN'(4);
    if (w_is_branch && bus.alu_branch) begin
      w_next_pc = r_pc + w_imm;
    end else if (w_is_jal) begin
      w_next_pc = r_pc + w_imm;
    end else if (w_is_jalr) begin
      w_next_pc = bus.alu_result & ~XLEN'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (w_fetch_accept) w_next_state = S_DECODE;
      S_DECODE: w_next_state = w_legal ? S_EXEC : S_ERROR;
      S_EXEC:   w_next_state = (w_is_load || w_is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (!bus.mem_busy) begin
          w_next_state = S_WB;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_next_state = S_ERROR;
        end
      end
      S_WB:     w_next_state = S_FETCH;
      S_ERROR:  w_next_state = S_ERROR;
      default:  w_next_state = S_ERROR;
    endcase
  end

  // Output decode for the state being entered, so strobes come straight from flops
  always_comb begin
    w_instr_req = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_error     = 1'b0;
    case (w_next_state)
      S_FETCH: w_instr_req = 1'b1;
      S_MEM: begin
        w_mem_read  = w_is_load;
        w_mem_write = w_is_store;
      end
      S_WB:    w_reg_write = w_writes_rd;
      S_ERROR: w_error = 1'b1;
      default: ;
    endcase
  end

  // Output strobe registers; all low while in reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_instr_req <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_instr_req <= w_instr_req;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      r_reg_write <= w_reg_write;
      r_error     <= w_error;
    end
  end

  // Instruction latch, PC and memory wait counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_instr    <= '0;
      r_pc       <= RESET_PC;
      r_wait_cnt <= '0;
    end else begin
      if (r_state == S_FETCH && w_fetch_accept) begin
        r_instr <= bus.instr_data;
      end
      if (r_state == S_WB) begin
        r_pc <= w_next_pc;
      end
      if (r_state == S_MEM && w_next_state == S_MEM) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign bus.pc         = r_pc;
  assign bus.instr      = r_instr;
  assign bus.immediate  = w_imm;
  assign bus.alu_source = w_alu_src;
  assign bus.instr_req  = r_instr_req;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.reg_write  = r_reg_write;
  assign bus.error      = r_error;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer.
module tb_control_sequencer;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int unsigned MEM_TIMEOUT = 16;

  logic clk;
  logic nrst;
  control_sequencer_if bus();

  control_sequencer #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] next_pc;
    logic        alu_src;
    logic        rw;
    logic        is_err;
    int          rd_cyc;
    int          wr_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic signed [31:0] t;
    t = $signed(v << (32 - bits));
    return $unsigned(t >>> (32 - bits));
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111};
  endfunction

  // Reference: what one instruction should do, from the ISA rules
  function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] pc,
                                   input int busy, input logic br, input logic [31:0] ares);
    exp_t e;
    logic [6:0] op;
    logic       is_mem;
    op        = ins[6:0];
    e.pc      = pc;
    e.instr   = ins;
    e.imm     = 32'd0;
    e.next_pc = pc + 32'd4;
    e.alu_src = 1'b0;
    e.rw      = 1'b0;
    e.is_err  = 1'b0;
    e.rd_cyc  = 0;
    e.wr_cyc  = 0;
    is_mem    = 1'b0;
    case (op)
      7'b0110011: e.rw = 1'b1;
      7'b0010011: begin e.imm = sext(32'(ins[31:20]), 12); e.alu_src = 1'b1; e.rw = 1'b1; end
      7'b0000011: begin e.imm = sext(32'(ins[31:20]), 12); e.alu_src = 1'b1; e.rw = 1'b1; is_mem = 1'b1; end
      7'b0100011: begin e.imm = sext(32'({ins[31:25], ins[11:7]}), 12); e.alu_src = 1'b1; is_mem = 1'b1; end
      7'b1100011: begin
        e.imm = sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
        if (br) e.next_pc = pc + e.imm;
      end
      7'b0110111: begin e.imm = sext(32'(ins[31:12]), 20); e.alu_src = 1'b1; e.rw = 1'b1; end
      7'b1101111: begin
        e.imm = sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
        e.rw = 1'b1;
        e.next_pc = pc + e.imm;
      end
      7'b1100111: begin
        e.imm = sext(32'(ins[31:20]), 12); e.alu_src = 1'b1; e.rw = 1'b1;
        e.next_pc = {ares[31:1], 1'b0};
      end
      default: e.is_err = 1'b1;
    endcase
    if (is_mem) begin
      int cyc;
      if (busy >= int'(MEM_TIMEOUT)) begin
        e.is_err = 1'b1;
        cyc = int'(MEM_TIMEOUT);
      end else begin
        cyc = busy + 1;
      end
      if (op == 7'b0000011) e.rd_cyc = cyc; else e.wr_cyc = cyc;
    end
    if (e.is_err) begin
      e.rw = 1'b0;
      e.next_pc = pc;
    end
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic noise;
    bus.instr_ready = 1'($urandom);
    bus.instr_data  = $urandom;
    bus.mem_busy    = 1'($urandom);
    bus.alu_branch  = 1'($urandom);
    bus.alu_result  = $urandom;
  endtask

  task automatic do_reset;
    nrst = 1'b0;
    noise();
    repeat (2) tick();
    nrst = 1'b1;
  endtask

  // Drive one instruction; abort_mem >= 0 resets the DUT after that many MEM cycles
  task automatic run_instr(input logic [31:0] ins, input int fdelay, input int busy,
                           input logic br, input logic [31:0] ares, input int abort_mem);
    exp_t e;
    int   guard;
    int   memc;
    logic done;
    logic reset_done;
    e = predict(ins, model_pc, busy, br, ares);
    if (abort_mem < 0) sb.push_back(e);
    guard = 0;
    while (!(bus.state == 3'd0 && bus.instr_req) && guard < 50) begin
      noise();
      tick();
      guard++;
    end
    if (guard >= 50) begin
      fail_now("fetch_wait_timeout");
      sb.delete();
      do_reset();
      model_pc = RESET_PC;
      return;
    end
    repeat (fdelay) begin
      noise();
      bus.instr_ready = 1'b0;
      tick();
    end
    noise();
    bus.instr_ready = 1'b1;
    bus.instr_data  = ins;
    tick();
    memc = 0;
    guard = 0;
    done = 1'b0;
    reset_done = 1'b0;
    while (!done && guard < 100) begin
      noise();
      if (bus.state == 3'd3) begin
        if (abort_mem >= 0 && memc == abort_mem) begin
          do_reset();
          reset_done = 1'b1;
          done = 1'b1;
        end else begin
          bus.mem_busy = (memc < busy);
          memc++;
        end
      end
      if (!done) begin
        if (bus.state == 3'd4) begin
          bus.alu_branch = br;
          bus.alu_result = ares;
        end
        if (bus.state == 3'd5) begin
          repeat (4) begin
            noise();
            tick();
          end
          do_reset();
          reset_done = 1'b1;
          done = 1'b1;
        end else if (bus.state == 3'd0) begin
          done = 1'b1;
        end else begin
          tick();
          guard++;
        end
      end
    end
    if (!done) begin
      fail_now("instr_complete_timeout");
      sb.delete();
      do_reset();
      reset_done = 1'b1;
    end
    model_pc = reset_done ? RESET_PC : e.next_pc;
  endtask

  // Monitor: compares DUT behaviour against the scoreboard at WB / ERROR entry
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          rel    = 3;
  logic        err_active = 1'b0;
  logic [31:0] err_pc = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!nrst) begin
      chk("reset_outputs",
          64'({bus.state, bus.instr_req, bus.mem_read, bus.mem_write, bus.reg_write, bus.error}),
          64'(0));
      chk("reset_pc", 64'(bus.pc), 64'(RESET_PC));
      chk("reset_instr", 64'(bus.instr), 64'(0));
      rd_cnt = 0;
      wr_cnt = 0;
      err_active = 1'b0;
      rel = 0;
    end else begin
      if (rel < 3) rel++;
      if (rel == 2) chk("first_instr_req", 64'({bus.state, bus.instr_req}), 64'({3'd0, 1'b1}));
      if (bus.mem_read)  rd_cnt++;
      if (bus.mem_write) wr_cnt++;
      chk("strobe_vs_state",
          64'({bus.instr_req && bus.state != 3'd0,
               (bus.mem_read || bus.mem_write) && bus.state != 3'd3,
               bus.reg_write && bus.state != 3'd4}),
          64'(0));
      if (bus.state == 3'd4) begin
        if (sb.size() == 0) begin
          fail_now("sb_empty_at_wb");
        end else begin
          e = sb.pop_front();
          chk("wb_unexpected", 64'(e.is_err), 64'(0));
          chk("wb_pc", 64'(bus.pc), 64'(e.pc));
          chk("wb_instr", 64'(bus.instr), 64'(e.instr));
          chk("wb_immediate", 64'(bus.immediate), 64'(e.imm));
          chk("wb_alu_source", 64'(bus.alu_source), 64'(e.alu_src));
          chk("wb_reg_write", 64'(bus.reg_write), 64'(e.rw));
          chk("wb_mem_read_cycles", 64'(rd_cnt), 64'(e.rd_cyc));
          chk("wb_mem_write_cycles", 64'(wr_cnt), 64'(e.wr_cyc));
          chk("wb_error", 64'(bus.error), 64'(0));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end else if (bus.state == 3'd5) begin
        if (!err_active) begin
          if (sb.size() == 0) begin
            fail_now("sb_empty_at_error");
          end else begin
            e = sb.pop_front();
            chk("error_expected", 64'(e.is_err), 64'(1));
            chk("error_pc", 64'(bus.pc), 64'(e.pc));
            chk("error_instr", 64'(bus.instr), 64'(e.instr));
            chk("error_mem_read_cycles", 64'(rd_cnt), 64'(e.rd_cyc));
            chk("error_mem_write_cycles", 64'(wr_cnt), 64'(e.wr_cyc));
          end
          err_active = 1'b1;
          err_pc = bus.pc;
          rd_cnt = 0;
          wr_cnt = 0;
        end
        chk("error_hold",
            64'({bus.pc, bus.error, bus.instr_req, bus.mem_read, bus.mem_write, bus.reg_write}),
            64'({err_pc, 1'b1, 4'b0000}));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  oc;
    int          sel;
    int          busy;
    logic [6:0]  legal_ops [8];
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                  7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111};
    nrst = 1'b0;
    bus.instr_ready = 1'b0;
    bus.instr_data  = '0;
    bus.mem_busy    = 1'b0;
    bus.alu_branch  = 1'b0;
    bus.alu_result  = '0;
    model_pc = RESET_PC;
    repeat (3) tick();
    nrst = 1'b1;

    // Directed cases
    run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0, -1);      // ADDI x1,x0,5 at pc 0
    run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0, -1);
    run_instr(32'h0050_0093, 1, 0, 1'b0, 32'h0, -1);
    run_instr(32'h0050_0093, 2, 0, 1'b1, 32'h0, -1);      // alu_branch ignored, pc -> 0x10
    run_instr(32'h0000_0463, 0, 0, 1'b1, 32'h0, -1);      // BEQ +8 taken: 0x10 -> 0x18
    run_instr(32'h0000_0463, 0, 0, 1'b0, 32'h0, -1);      // BEQ not taken: 0x18 -> 0x1C
    run_instr(32'h0011_2223, 0, 3, 1'b0, 32'h0, -1);      // SW, busy 3 cycles
    run_instr(32'h0000_80e7, 0, 0, 1'b0, 32'h0000_0103, -1); // JALR -> 0x102
    run_instr(32'h0041_2083, 0, 100, 1'b0, 32'h0, -1);    // LW stuck busy -> timeout
    run_instr(32'h0000_0093, 0, 0, 1'b0, 32'h0, -1);
    run_instr(32'h0000_007F, 0, 0, 1'b0, 32'h0, -1);      // illegal opcode
    run_instr(32'h0041_2083, 0, 1000, 1'b0, 32'h0, 3);    // LW aborted by reset mid-MEM
    run_instr(32'h0041_2083, 0, 15, 1'b0, 32'h0, -1);     // LW one short of timeout
    run_instr(32'h0041_2083, 0, 16, 1'b0, 32'h0, -1);     // LW exactly at timeout
    run_instr(32'hFFF0_0093, 0, 0, 1'b0, 32'h0, -1);      // ADDI negative immediate
    run_instr(32'h8000_006F, 0, 0, 1'b0, 32'h0, -1);      // JAL most negative offset (wraps)

    // Randomized instruction stream
    for (int n = 0; n < 120; n++) begin
      ins = $urandom;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        oc = 7'($urandom);
        for (int k = 0; k < 64 && is_legal(oc); k++) oc = 7'($urandom);
        if (is_legal(oc)) oc = 7'b1111111;
      end else begin
        oc = legal_ops[sel % 8];
      end
      ins[6:0] = oc;
      busy = ($urandom_range(0, 19) == 0) ? int'($urandom_range(16, 18))
                                            : int'($urandom_range(0, 4));
      run_instr(ins, int'($urandom_range(0, 2)), busy, 1'($urandom), $urandom, -1);
    end

    repeat (3) tick();
    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    chk("final_pc", 64'(bus.pc), 64'(model_pc));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
